fpu: RTL and testbench
======================

// Module: fpu
// PURPOSE
//  Multi-cycle IEEE-754 single-precision FPU: add, sub, mul, div of two 32-bit operands.
//  Round-to-nearest-even; subnormals handled fully on inputs and outputs; no exception flags.
//  Slave coprocessor: host drives operands/op, raises start, waits for cmd_end, reads result.
// PARAMETERS
//  none (format fixed: 1 sign, 8 exponent bias 127, 23 fraction)
// PORTS
//  clk              in   1   system clock, all logic on rising edge
//  arst             in   1   reset: synchronous, active-high (named arst, but NOT asynchronous)
//  start            in   1   level request; sampled only in IDLE
//  a_operand        in   32  IEEE single operand A
//  b_operand        in   32  IEEE single operand B
//  operation        in   2   pa_fpu::e_fpu_op: op_add=0, op_sub=1, op_mul=2, op_div=3
//  ieee_packet_out  out  32  result, valid from cmd_end cycle, held until next capture
//  cmd_end          out  1   one-cycle completion pulse (usable as irq)
//  busy             out  1   high while an operation is in progress
// BEHAVIOUR
//  Reset (arst=1 at clk edge): FSM->IDLE, ieee_packet_out=0, cmd_end=0, busy=0.
//   Reset mid-operation aborts silently: no cmd_end, result register cleared.
//  FSM: IDLE -> UNPACK -> CALC -> NORM -> ROUND -> DONE -> RELEASE -> IDLE.
//   IDLE: start=1 => register a, b, operation; busy=1 from next cycle.
//   UNPACK: split fields; hidden bit=1 if exp!=0 else 0, subnormal exp treated as 1;
//    classify zero/sub/normal/inf/NaN; resolve specials.
//   CALC: add/sub 1 cycle (sub = add with B sign inverted; align smaller by exp diff,
//    keep guard/round/sticky, shifts >=27 collapse to sticky); mul 1 cycle 24x24->48;
//    div 27 cycles restoring, 1 quotient bit/cycle, remainder!=0 -> sticky.
//   NORM: leading-one normalise; exp underflow -> right-shift to subnormal with sticky.
//   ROUND: RNE on guard/round/sticky; mantissa carry-out bumps exponent;
//    exp>=255 -> +-inf; pack result.
//   DONE: ieee_packet_out updated, cmd_end=1 for exactly this cycle, busy=1.
//   RELEASE: busy=0; wait until start=0, then IDLE (start held high never re-triggers).
//  Latency capture->cmd_end: add/sub/mul 5 clocks; div 31 clocks; specials same latency.
//  Operand/op changes after capture ignored.
//  Specials (canonical NaN = 32'h7FC00000, NaN inputs never propagated):
//   any NaN input -> NaN; inf-inf (effective) -> NaN; 0*inf -> NaN; 0/0, inf/inf -> NaN.
//   inf op finite -> inf, sign per op; x/0 (x finite !=0) -> inf, sign = sa^sb.
//   finite/inf -> signed 0; exact zero sum -> +0, except (-0)+(-0) -> -0.
//   mul/div sign always sa^sb, including zero results.
// TESTING
//  add 3F800000 + 3F8CCCCD -> 40066666; sub same pair -> BDCCCCD0; cmd_end 5 clk after capture.
//  mul 41800000 * 42000000 -> 44000000; div 3E800000 / 3F000000 -> 3F000000 at 31 clk.
//  sub 00000001 - 00000000 -> 00000001 (subnormal kept);
//   add 00800000 + 80000001 -> 007FFFFF.
//  specials: sub 7F800000-7F800000 -> 7FC00000; div 42168F5C/0 -> 7F800000;
//   mul 0*7F800000 -> 7FC00000; add 7FC00000+402DF854 -> 7FC00000.
//  handshake: hold start=1 after cmd_end -> no second op, no second cmd_end;
//   drop start -> next start accepted.
//  reset mid-div (arst at cycle 10) -> busy=0, no cmd_end, ieee_packet_out=0 next cycle.

Source files
------------

// File: rtl/fpu.sv
// fpu: multi-cycle IEEE-754 single-precision coprocessor (add, sub, mul, div).
// Round-to-nearest-even, full subnormal support, canonical quiet NaN, no exception flags.
// Ports:
//   clk             - system clock, rising edge
//   arst            - synchronous active-high reset
//   start           - level request, sampled only while idle
//   a_operand       - IEEE single operand A
//   b_operand       - IEEE single operand B
//   operation       - 0 add, 1 sub, 2 mul, 3 div
//   ieee_packet_out - result, updated in the completion cycle and held until the next one
//   cmd_end         - one-cycle completion pulse
//   busy            - high while an operation is in progress
module fpu (
    input  logic        clk,
    input  logic        arst,
    input  logic        start,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic [1:0]  operation,
    output logic [31:0] ieee_packet_out,
    output logic        cmd_end,
    output logic        busy
);

    typedef enum logic [1:0] {OpAdd = 2'd0, OpSub = 2'd1, OpMul = 2'd2, OpDiv = 2'd3} e_fpu_op;
    typedef enum logic [2:0] {
        StIdle, StUnpack, StCalc, StNorm, StRound, StDone, StRelease
    } state_e;

    localparam logic [31:0] QNan   = 32'h7FC0_0000;
    localparam logic [30:0] InfMag = 31'h7F80_0000;

    state_e             state_q;
    e_fpu_op            op_q;
    logic [31:0]        a_q, b_q;
    logic               sign_a_q, sign_b_q;   // sign_b_q already inverted for sub
    logic signed [11:0] exp_a_q, exp_b_q;
    logic [23:0]        man_a_q, man_b_q;     // normalised: bit 23 set unless zero
    logic               special_q;
    logic [31:0]        special_res_q;
    logic [24:0]        rem_q;
    logic [26:0]        quo_q;
    logic [4:0]         cnt_q;
    // Pre-normalisation value: m_q / 2^48 * 2^(e_q - 127)
    logic [49:0]        m_q;
    logic signed [11:0] e_q;
    logic               sign_r_q;
    logic [48:0]        nm_q;
    logic signed [11:0] ne_q;
    logic               ns_q;

    // Expand to {signed exponent, 24-bit mantissa} with subnormals shifted up so bit 23 is
    // the leading one. Zero gets a very low exponent so it always aligns as the smaller addend.
    function automatic logic [35:0] unpack_norm(input logic [31:0] x);
        logic [23:0]        m;
        logic signed [11:0] e;
        m = {(x[30:23] != 8'd0), x[22:0]};
        e = (x[30:23] == 8'd0) ? 12'sd1 : $signed({4'd0, x[30:23]});
        if (m == 24'd0) begin
            e = -12'sd100;
        end else begin
            for (int i = 0; i < 23; i++) begin
                if (!m[23]) begin
                    m = m << 1;
                    e = e - 12'sd1;
                end
            end
        end
        return {e, m};
    endfunction

    // ---------------- unpack / special resolution ----------------
    logic               a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, sb_eff, s_xor;
    logic signed [11:0] ea_u, eb_u;
    logic [23:0]        ma_u, mb_u;
    logic               spec_u;
    logic [31:0]        spec_res_u;

    always_comb begin
        a_nan  = (&a_q[30:23]) && (|a_q[22:0]);
        a_inf  = (&a_q[30:23]) && !(|a_q[22:0]);
        a_zero = (a_q[30:0] == 31'd0);
        b_nan  = (&b_q[30:23]) && (|b_q[22:0]);
        b_inf  = (&b_q[30:23]) && !(|b_q[22:0]);
        b_zero = (b_q[30:0] == 31'd0);
        sb_eff = b_q[31] ^ (op_q == OpSub);
        s_xor  = a_q[31] ^ b_q[31];
        {ea_u, ma_u} = unpack_norm(a_q);
        {eb_u, mb_u} = unpack_norm(b_q);
        spec_u     = 1'b1;
        spec_res_u = QNan;
        if (!(a_nan || b_nan)) begin
            case (op_q)
                OpAdd, OpSub: begin
                    if (a_inf && b_inf)  spec_res_u = (a_q[31] == sb_eff) ? {a_q[31], InfMag} : QNan;
                    else if (a_inf)      spec_res_u = {a_q[31], InfMag};
                    else if (b_inf)      spec_res_u = {sb_eff, InfMag};
                    else                 spec_u = 1'b0;
                end
                OpMul: begin
                    if ((a_inf && b_zero) || (a_zero && b_inf)) spec_res_u = QNan;
                    else if (a_inf || b_inf)                    spec_res_u = {s_xor, InfMag};
                    else if (a_zero || b_zero)                  spec_res_u = {s_xor, 31'd0};
                    else                                        spec_u = 1'b0;
                end
                default: begin
                    if ((a_zero && b_zero) || (a_inf && b_inf)) spec_res_u = QNan;
                    else if (a_inf || b_zero)                   spec_res_u = {s_xor, InfMag};
                    else if (b_inf || a_zero)                   spec_res_u = {s_xor, 31'd0};
                    else                                        spec_u = 1'b0;
                end
            endcase
        end
    end

    // ---------------- calc: add/sub alignment, multiply, division step ----------------
    logic               big_is_a, s_big, add_sign, ge;
    logic signed [11:0] e_big, e_sml, diff;
    logic [23:0]        m_big, m_sml;
    logic [5:0]         sh;
    logic [97:0]        ext;
    logic [48:0]        aligned;
    logic [49:0]        sum;
    logic [47:0]        prod;
    logic [24:0]        rem_sub, rem_next;
    logic [26:0]        quo_next;

    always_comb begin
        big_is_a = (exp_a_q > exp_b_q) || ((exp_a_q == exp_b_q) && (man_a_q >= man_b_q));
        e_big    = big_is_a ? exp_a_q : exp_b_q;
        e_sml    = big_is_a ? exp_b_q : exp_a_q;
        m_big    = big_is_a ? man_a_q : man_b_q;
        m_sml    = big_is_a ? man_b_q : man_a_q;
        s_big    = big_is_a ? sign_a_q : sign_b_q;
        diff     = e_big - e_sml;
        // Beyond 49 places the whole addend is below the sticky bit
        sh       = (diff > 12'sd49) ? 6'd49 : diff[5:0];
        ext      = {m_sml, 25'd0, 49'd0} >> sh;
        aligned  = ext[97:49] | {48'd0, |ext[48:0]};
        if (sign_a_q == sign_b_q) sum = {1'b0, m_big, 25'd0} + {1'b0, aligned};
        else                      sum = {1'b0, m_big, 25'd0} - {1'b0, aligned};
        // Exact zero is +0 unless both addends are negative
        add_sign = (sum == 50'd0) ? (sign_a_q & sign_b_q) : s_big;
        prod     = man_a_q * man_b_q;
        ge       = (rem_q >= {1'b0, man_b_q});
        rem_sub  = ge ? (rem_q - {1'b0, man_b_q}) : rem_q;
        rem_next = rem_sub << 1;
        quo_next = (quo_q << 1) | {26'd0, ge};
    end

    // ---------------- normalise ----------------
    logic [5:0]         lead, lshift, ush;
    logic [48:0]        nm;
    logic signed [11:0] ne, un;
    logic [97:0]        uext;

    always_comb begin
        lead = 6'd0;
        for (int i = 0; i < 50; i++) begin
            if (m_q[i]) lead = 6'(i);
        end
        lshift = 6'd48 - lead;
        un     = 12'sd0;
        ush    = 6'd0;
        uext   = 98'd0;
        if (m_q == 50'd0) begin
            nm = 49'd0;
            ne = 12'sd0;
        end else if (lead == 6'd49) begin
            nm = {m_q[49:2], m_q[1] | m_q[0]};
            ne = e_q + 12'sd1;
        end else begin
            nm = m_q[48:0] << lshift;
            ne = e_q - $signed({6'd0, lshift});
        end
        // Below the normal range: denormalise to exponent 1 and encode as subnormal
        if (ne < 12'sd1) begin
            un   = 12'sd1 - ne;
            ush  = (un > 12'sd49) ? 6'd49 : un[5:0];
            uext = {nm, 49'd0} >> ush;
            nm   = uext[97:49] | {48'd0, |uext[48:0]};
            ne   = 12'sd0;
        end
    end

    // ---------------- round and pack ----------------
    logic        inc;
    logic [7:0]  field;
    logic [30:0] pk;
    logic [31:0] round_res;

    always_comb begin
        inc   = nm_q[24] & ((|nm_q[23:0]) | nm_q[25]);
        field = nm_q[48] ? ne_q[7:0] : 8'd0;
        // Mantissa carry-out ripples into the exponent field (and up to infinity)
        pk    = {field, nm_q[47:25]} + {30'd0, inc};
        if (special_q)               round_res = special_res_q;
        else if (ne_q >= 12'sd255)   round_res = {ns_q, InfMag};
        else                         round_res = {ns_q, pk};
    end

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q         <= StIdle;
            ieee_packet_out <= 32'd0;
            cmd_end         <= 1'b0;
            busy            <= 1'b0;
        end else begin
            cmd_end <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a_operand;
                        b_q     <= b_operand;
                        op_q    <= e_fpu_op'(operation);
                        busy    <= 1'b1;
                        state_q <= StUnpack;
                    end
                end
                StUnpack: begin
                    sign_a_q      <= a_q[31];
                    sign_b_q      <= sb_eff;
                    exp_a_q       <= ea_u;
                    exp_b_q       <= eb_u;
                    man_a_q       <= ma_u;
                    man_b_q       <= mb_u;
                    special_q     <= spec_u;
                    special_res_q <= spec_res_u;
                    rem_q         <= {1'b0, ma_u};
                    quo_q         <= 27'd0;
                    cnt_q         <= 5'd0;
                    state_q       <= StCalc;
                end
                StCalc: begin
                    if (op_q == OpDiv) begin
                        quo_q <= quo_next;
                        rem_q <= rem_next;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd26) begin
                            // Quotient integer bit lands on bit 48; leftover remainder is sticky
                            m_q      <= {1'b0, quo_next, rem_next != 25'd0, 21'd0};
                            e_q      <= exp_a_q - exp_b_q + 12'sd127;
                            sign_r_q <= sign_a_q ^ sign_b_q;
                            state_q  <= StNorm;
                        end
                    end else if (op_q == OpMul) begin
                        m_q      <= {prod, 2'b00};
                        e_q      <= exp_a_q + exp_b_q - 12'sd127;
                        sign_r_q <= sign_a_q ^ sign_b_q;
                        state_q  <= StNorm;
                    end else begin
                        m_q      <= sum;
                        e_q      <= e_big;
                        sign_r_q <= add_sign;
                        state_q  <= StNorm;
                    end
                end
                StNorm: begin
                    nm_q    <= nm;
                    ne_q    <= ne;
                    ns_q    <= sign_r_q;
                    state_q <= StRound;
                end
                StRound: begin
                    ieee_packet_out <= round_res;
                    cmd_end         <= 1'b1;
                    state_q         <= StDone;
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StRelease;
                end
                StRelease: begin
                    if (!start) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu.sv
// Directed self-checking bench for fpu: arithmetic vectors, specials, latency,
// start handshake and abort by reset.
module tb_fpu;

    logic        clk = 1'b0;
    logic        arst;
    logic        start;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic [1:0]  operation;
    logic [31:0] ieee_packet_out;
    logic        cmd_end;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    fpu dut (
        .clk             (clk),
        .arst            (arst),
        .start           (start),
        .a_operand       (a_operand),
        .b_operand       (b_operand),
        .operation       (operation),
        .ieee_packet_out (ieee_packet_out),
        .cmd_end         (cmd_end),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue one operation, scramble the inputs after capture, wait for cmd_end and check
    // result, latency and busy. With hold set, start stays high for a while afterwards.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] expv, input int exp_lat,
                          input bit hold);
        int lat;
        int extra;
        int busy_hi;
        bit seen;
        a_operand = a;
        b_operand = b;
        operation = op;
        start     = 1'b1;
        @(posedge clk);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            lat++;
            a_operand = $urandom;
            b_operand = $urandom;
            operation = op + 2'd1;
            if (cmd_end) seen = 1'b1;
        end
        check({tag, "/cmd_end"}, 32'(seen), 32'd1);
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/result"}, ieee_packet_out, expv);
        check({tag, "/busy_done"}, 32'(busy), 32'd1);
        if (hold) begin
            extra   = 0;
            busy_hi = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (cmd_end) extra++;
                if (busy) busy_hi++;
            end
            check({tag, "/hold_no_cmd_end"}, 32'(extra), 32'd0);
            check({tag, "/hold_no_busy"}, 32'(busy_hi), 32'd0);
            check({tag, "/hold_result"}, ieee_packet_out, expv);
            start = 1'b0;
            @(negedge clk);
        end else begin
            start = 1'b0;
            @(negedge clk);
            check({tag, "/busy_release"}, 32'(busy), 32'd0);
            check({tag, "/cmd_end_pulse"}, 32'(cmd_end), 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        int seen;
        arst      = 1'b1;
        start     = 1'b0;
        a_operand = 32'd0;
        b_operand = 32'd0;
        operation = 2'd0;
        repeat (2) @(negedge clk);
        check("reset/out", ieee_packet_out, 32'd0);
        check("reset/cmd_end", 32'(cmd_end), 32'd0);
        check("reset/busy", 32'(busy), 32'd0);
        arst = 1'b0;
        @(negedge clk);

        run_op("add_1p0_1p1",   32'h3F80_0000, 32'h3F8C_CCCD, 2'd0, 32'h4006_6666, 5, 1'b0);
        run_op("sub_1p0_1p1",   32'h3F80_0000, 32'h3F8C_CCCD, 2'd1, 32'hBDCC_CCD0, 5, 1'b0);
        run_op("mul_16_32",     32'h4180_0000, 32'h4200_0000, 2'd2, 32'h4400_0000, 5, 1'b0);
        run_op("div_qtr_half",  32'h3E80_0000, 32'h3F00_0000, 2'd3, 32'h3F00_0000, 31, 1'b0);
        run_op("div_1_3",       32'h3F80_0000, 32'h4040_0000, 2'd3, 32'h3EAA_AAAB, 31, 1'b0);
        run_op("sub_denorm",    32'h0000_0001, 32'h0000_0000, 2'd1, 32'h0000_0001, 5, 1'b0);
        run_op("add_to_denorm", 32'h0080_0000, 32'h8000_0001, 2'd0, 32'h007F_FFFF, 5, 1'b0);
        run_op("rne_tie_even",  32'h3F80_0000, 32'h3380_0000, 2'd0, 32'h3F80_0000, 5, 1'b0);
        run_op("rne_tie_up",    32'h3F80_0001, 32'h3380_0000, 2'd0, 32'h3F80_0002, 5, 1'b0);
        run_op("add_cancel",    32'h3F80_0000, 32'hBF80_0000, 2'd0, 32'h0000_0000, 5, 1'b0);
        run_op("add_neg_zeros", 32'h8000_0000, 32'h8000_0000, 2'd0, 32'h8000_0000, 5, 1'b0);
        run_op("mul_neg_zero",  32'h8000_0000, 32'h3F80_0000, 2'd2, 32'h8000_0000, 5, 1'b0);
        run_op("mul_overflow",  32'h7F00_0000, 32'h4000_0000, 2'd2, 32'h7F80_0000, 5, 1'b0);
        run_op("inf_minus_inf", 32'h7F80_0000, 32'h7F80_0000, 2'd1, 32'h7FC0_0000, 5, 1'b0);
        run_op("div_by_zero",   32'h4216_8F5C, 32'h0000_0000, 2'd3, 32'h7F80_0000, 31, 1'b0);
        run_op("zero_mul_inf",  32'h0000_0000, 32'h7F80_0000, 2'd2, 32'h7FC0_0000, 5, 1'b0);
        run_op("nan_add",       32'h7FC0_0000, 32'h402D_F854, 2'd0, 32'h7FC0_0000, 5, 1'b0);
        run_op("div_by_inf",    32'hC000_0000, 32'h7F80_0000, 2'd3, 32'h8000_0000, 31, 1'b0);

        // start held high after completion must not retrigger; next request still accepted
        run_op("hold_add",      32'h4000_0000, 32'h4000_0000, 2'd0, 32'h4080_0000, 5, 1'b1);
        run_op("after_hold",    32'h4040_0000, 32'h4000_0000, 2'd2, 32'h40C0_0000, 5, 1'b0);

        // Reset in the middle of a division aborts it silently
        a_operand = 32'h3F80_0000;
        b_operand = 32'h4040_0000;
        operation = 2'd3;
        start     = 1'b1;
        @(posedge clk);
        repeat (10) @(negedge clk);
        check("abort/busy_before", 32'(busy), 32'd1);
        arst  = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/cmd_end", 32'(cmd_end), 32'd0);
        check("abort/out", ieee_packet_out, 32'd0);
        arst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_end) seen++;
        end
        check("abort/no_cmd_end", 32'(seen), 32'd0);
        check("abort/out_held", ieee_packet_out, 32'd0);

        run_op("after_abort",   32'h3F80_0000, 32'h4000_0000, 2'd1, 32'hBF80_0000, 5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
